ref_row_fetcher: RTL and testbench
==================================

Name: ref_row_fetcher

Overview:
- Transmit side of the interpolator's row input. Reads a 15x16 reference-pixel window at (blk_x, blk_y) from frame memory and buffers all 16 rows locally.
- Streams the rows as in_row, one per cycle, in the 16-cycle load window signalled by frame_sync. That window is the interpolator's load_in phase, counter values 0..15 of its 47-cycle period.
- Sits between the frame-memory port and the subpixel_interpolation in_row input.

Parameters:
- FRAME_W, 64, frame width in pixels; must be a multiple of 16.
- FRAME_H, 64, frame height in pixels.
- ROWS, 16, rows per window.
- PIX, 15, pixels per row.
- PIX_W, 8, bits per pixel.
- ADDR_W, 8, memory word-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to fetch a window; sampled only in IDLE.
- blk_x  in  8  window left pixel column; blk_x+PIX <= FRAME_W.
- blk_y  in  8  window top row; blk_y+ROWS <= FRAME_H.
- frame_sync  in  1  pulse one cycle before the interpolator's load window.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  ADDR_W  word address = row*(FRAME_W/16) + column/16.
- mem_rdata  in  128  16 pixels; pixel i at [8i+:8]; valid the cycle after mem_rd.
- in_row  out  PIX*PIX_W (120)  streamed row; pixel k at [8k+:8] = frame(blk_x+k, row).
- row_valid  out  1  in_row carries a window row.
- row_idx  out  4  index of the row on in_row.
- busy  out  1  high in FETCH, READY and STREAM.
- done  out  1  one-cycle pulse after row 15 is streamed.

Behaviour:
- Reset: every output is 0 (in_row, row_valid, row_idx, busy, done, mem_rd, mem_addr); FSM goes to IDLE; buffer contents don't-care. Reset asserted in any state aborts within the same cycle, and nothing is streamed afterwards.
- Clock and reset: one clock; reset is synchronous and active-high.
- IDLE: start=1 latches blk_x and blk_y; next state FETCH.
- FETCH, read count per row:
  - off = blk_x%16, w = blk_x/16.
  - off <= 1: the row fits in one word; one read at w.
  - off >= 2: two reads, at w then w+1.
- FETCH, read issue:
  - One read per cycle, back to back, rows 0..15 in order; first read the cycle after start.
  - N = 16 or 32 reads.
- FETCH, row assembly:
  - Row data = {second word, first word} >> (8*off), truncated to 120 bits.
  - Single-word case: the upper word is treated as 0; it is never selected.
  - Written to buffer entry r the cycle the last word of row r returns.
- FETCH -> READY: the cycle after the final read data returns. With start at cycle 0, READY is entered at cycle N+2.
- READY: waits for frame_sync. frame_sync is accepted only when the registered state is READY; pulses in IDLE or FETCH are ignored, and the bench waits for the next one.
- STREAM:
  - frame_sync accepted at cycle t gives row r on in_row with row_valid=1 and row_idx=r at cycle t+1+r, for r = 0..15.
  - frame_sync inside STREAM is ignored.
- STREAM -> IDLE: at cycle t+17, done=1 for one cycle, busy=0, row_valid=0, in_row=0.
- Outside STREAM: in_row=0 and row_valid=0.
- start while busy: ignored; the latched coordinates are unchanged.
- busy: 1 from the cycle after start is accepted through the last streamed row.
- mem_rd/mem_addr: registered outputs. mem_addr holds its last value when mem_rd=0.

Test Plan:
1. Memory pixel(x,y) = (x+3y)&255; start with blk_x=0, blk_y=0 -> 16 reads at addr 0,4,..,60 on cycles 1..16. After READY, frame_sync gives row 0 = pixels 0..14, i.e. in_row[7:0]=0 and in_row[119:112]=14. Row 15 [7:0] = 45.
2. blk_x=17, blk_y=2 -> off=1, one read per row at addr 9,13,..; row 0 [7:0]=23, [119:112]=37.
3. blk_x=20, blk_y=0 -> 32 reads at addr 1,2,5,6,...; READY at cycle 34. Row 0 pixels 20..34 straddle the word boundary correctly.
4. frame_sync pulsed during FETCH, and again in READY -> only the READY pulse starts streaming; exactly 16 row_valid cycles, then done pulse, busy=0.
5. start pulsed at cycle 5 of FETCH with different coordinates -> ignored; streamed data matches the first request.
6. rst asserted at row 7 of STREAM -> the next cycle has all outputs 0, state IDLE. A new start afterwards completes normally.

Source files
------------

// File: rtl/ref_row_fetcher_if.sv
// Bus bundle for the reference-row fetcher: frame-memory read port and row stream toward the interpolator.
interface ref_row_fetcher_if #(
  parameter int ADDR_W = 8,
  parameter int PIX    = 15,
  parameter int PIX_W  = 8
);
  logic                  mem_rd;
  logic [ADDR_W-1:0]     mem_addr;
  logic [16*PIX_W-1:0]   mem_rdata;
  logic [PIX*PIX_W-1:0]  in_row;
  logic                  row_valid;
  logic [3:0]            row_idx;

  modport master (
    output mem_rd, mem_addr, in_row, row_valid, row_idx,
    input  mem_rdata
  );

  modport slave (
    input  mem_rd, mem_addr, in_row, row_valid, row_idx,
    output mem_rdata
  );
endinterface

// File: rtl/ref_row_fetcher.sv
// Fetches a PIX x ROWS reference window from frame memory into a local row buffer,
// then streams it one row per cycle into the interpolator's load window after frame_sync.
module ref_row_fetcher #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ROWS    = 16,
  parameter int PIX     = 15,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          blk_x,
  input  logic [7:0]          blk_y,
  input  logic                frame_sync,
  ref_row_fetcher_if.master   bus,
  output logic                busy,
  output logic                done
);

  localparam int WORD_W = 16 * PIX_W;
  localparam int ROW_W  = PIX * PIX_W;
  localparam int WPR    = FRAME_W / 16;
  localparam int IDX_W  = $clog2(2 * ROWS);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_READY, S_STREAM} state_t;

  state_t             r_state, w_next;
  logic [7:0]         r_blk_x, r_blk_y;
  logic               r_mem_rd;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [IDX_W-1:0]   r_iss_idx_p0;
  logic               r_vld_p1;
  logic [IDX_W-1:0]   r_idx_p1;
  logic [WORD_W-1:0]  r_lo_p2;
  logic [ROW_W-1:0]   r_buf [ROWS];
  logic [ROW_W-1:0]   r_in_row;
  logic               r_row_valid;
  logic [3:0]         r_row_idx;
  logic               r_done;

  logic [3:0]         w_off;
  logic               w_two;
  logic [IDX_W-1:0]   w_last_idx;
  logic               w_accept;
  logic               w_issue;
  logic               w_ret_last;
  logic               w_wr;
  logic [3:0]         w_wr_row;
  logic [WORD_W-1:0]  w_hi, w_lo;

  // Word address of read idx; in the two-word case odd reads fetch the right-hand neighbour word.
  function automatic logic [ADDR_W-1:0] f_addr(input logic [7:0] y, input logic [7:0] x,
                                               input logic [IDX_W-1:0] idx, input logic two);
    logic [IDX_W-1:0] row;
    int               a;
    row = two ? (idx >> 1) : idx;
    a = ((int'(y) + int'(row)) % FRAME_H) * WPR + int'(x >> 4) + int'(two & idx[0]);
    return ADDR_W'(a);
  endfunction

  function automatic logic [ROW_W-1:0] f_align(input logic [WORD_W-1:0] hi,
                                               input logic [WORD_W-1:0] lo,
                                               input logic [3:0] off);
    logic [2*WORD_W-1:0] cat;
    cat = {hi, lo} >> (int'(off) * PIX_W);
    return cat[ROW_W-1:0];
  endfunction

  assign w_off      = r_blk_x[3:0];
  assign w_two      = (w_off >= 4'd2);
  assign w_last_idx = w_two ? IDX_W'(2 * ROWS - 1) : IDX_W'(ROWS - 1);
  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_issue    = (r_state == S_FETCH) && r_mem_rd && (r_iss_idx_p0 != w_last_idx);
  assign w_ret_last = r_vld_p1 && (r_idx_p1 == w_last_idx);
  assign w_wr       = r_vld_p1 && (!w_two || r_idx_p1[0]);
  assign w_wr_row   = w_two ? r_idx_p1[4:1] : r_idx_p1[3:0];
  assign w_hi       = w_two ? bus.mem_rdata : '0;
  assign w_lo       = w_two ? r_lo_p2 : bus.mem_rdata;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start)                       w_next = S_FETCH;
      S_FETCH:  if (w_ret_last)                  w_next = S_READY;
      S_READY:  if (frame_sync)                  w_next = S_STREAM;
      S_STREAM: if (r_row_idx == 4'(ROWS - 1))   w_next = S_IDLE;
      default:                                   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Stage p0: read issue; p1: read data return; stream output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
      r_vld_p1    <= 1'b0;
      r_in_row    <= '0;
      r_row_valid <= 1'b0;
      r_row_idx   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_vld_p1    <= r_mem_rd;
      r_mem_rd    <= 1'b0;
      r_done      <= 1'b0;
      r_row_valid <= 1'b0;
      r_in_row    <= '0;
      if (w_accept) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= f_addr(blk_y, blk_x, '0, 1'b0);
      end else if (w_issue) begin
        r_mem_rd   <= 1'b1;
        r_mem_addr <= f_addr(r_blk_y, r_blk_x, r_iss_idx_p0 + 1'b1, w_two);
      end
      if (r_state == S_READY && frame_sync) begin
        r_row_valid <= 1'b1;
        r_row_idx   <= '0;
        r_in_row    <= r_buf[0];
      end else if (r_state == S_STREAM) begin
        if (r_row_idx != 4'(ROWS - 1)) begin
          r_row_valid <= 1'b1;
          r_row_idx   <= r_row_idx + 4'd1;
          r_in_row    <= r_buf[r_row_idx + 4'd1];
        end else begin
          r_done    <= 1'b1;
          r_row_idx <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_blk_x      <= blk_x;
      r_blk_y      <= blk_y;
      r_iss_idx_p0 <= '0;
    end else if (w_issue) begin
      r_iss_idx_p0 <= r_iss_idx_p0 + 1'b1;
    end
    r_idx_p1 <= r_iss_idx_p0;
    if (r_vld_p1 && w_two && !r_idx_p1[0]) r_lo_p2 <= bus.mem_rdata;
    if (w_wr) r_buf[w_wr_row] <= f_align(w_hi, w_lo, w_off);
  end

  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.in_row    = r_in_row;
  assign bus.row_valid = r_row_valid;
  assign bus.row_idx   = r_row_idx;
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;

endmodule

// File: tb/tb_ref_row_fetcher.sv
// Directed bench for ref_row_fetcher with a behavioural frame memory holding pixel(x,y) = (x+3y)&255.
module tb_ref_row_fetcher;
  logic       clk;
  logic       rst;
  logic       start;
  logic       frame_sync;
  logic [7:0] blk_x, blk_y;
  logic       busy, done;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [119:0] rows [16];

  ref_row_fetcher_if #(.ADDR_W(8), .PIX(15), .PIX_W(8)) bus ();

  ref_row_fetcher dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .blk_x      (blk_x),
    .blk_y      (blk_y),
    .frame_sync (frame_sync),
    .bus        (bus),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pix(input int x, input int y);
    return 8'((x + 3 * y) & 255);
  endfunction

  function automatic logic [127:0] mem_word(input int a);
    logic [127:0] w;
    for (int i = 0; i < 16; i++) w[8*i +: 8] = pix(16 * (a % 4) + i, a / 4);
    return w;
  endfunction

  function automatic logic [119:0] exp_row(input int bx, input int by, input int r);
    logic [119:0] v;
    for (int k = 0; k < 15; k++) v[8*k +: 8] = pix(bx + k, by + r);
    return v;
  endfunction

  function automatic int exp_addr(input int bx, input int by, input int j);
    int two;
    two = ((bx % 16) >= 2) ? 1 : 0;
    return (by + (two != 0 ? j / 2 : j)) * 4 + bx / 16 + (two != 0 ? j % 2 : 0);
  endfunction

  always @(posedge clk) if (bus.mem_rd) bus.mem_rdata <= mem_word(int'(bus.mem_addr));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_chk++;
    assert (obs === expv)
      else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_mem_rd"},    128'(bus.mem_rd),    128'(0));
    chk({tag, "_mem_addr"},  128'(bus.mem_addr),  128'(0));
    chk({tag, "_in_row"},    128'(bus.in_row),    128'(0));
    chk({tag, "_row_valid"}, 128'(bus.row_valid), 128'(0));
    chk({tag, "_row_idx"},   128'(bus.row_idx),   128'(0));
    chk({tag, "_busy"},      128'(busy),          128'(0));
    chk({tag, "_done"},      128'(done),          128'(0));
  endtask

  // fs_at / st_at: FETCH cycle (1-based) on which to inject a stray frame_sync / start.
  task automatic do_fetch(input int bx, input int by, input int fs_at, input int st_at);
    int n;
    n = ((bx % 16) >= 2) ? 32 : 16;
    blk_x = 8'(bx);
    blk_y = 8'(by);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int j = 0; j < n; j++) begin
      chk("mem_rd_fetch", 128'(bus.mem_rd),   128'(1));
      chk("mem_addr",     128'(bus.mem_addr), 128'(exp_addr(bx, by, j)));
      chk("busy_fetch",   128'(busy),         128'(1));
      if (j + 1 == fs_at) frame_sync = 1'b1;
      if (j + 1 == st_at) begin
        start = 1'b1;
        blk_x = 8'd32;
        blk_y = 8'd16;
      end
      step();
      frame_sync = 1'b0;
      start      = 1'b0;
    end
    chk("mem_rd_after",  128'(bus.mem_rd),   128'(0));
    chk("mem_addr_hold", 128'(bus.mem_addr), 128'(exp_addr(bx, by, n - 1)));
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    chk("sync_in_fetch_ignored", 128'(bus.row_valid), 128'(0));
  endtask

  task automatic do_stream(input int bx, input int by, input int wait_cyc,
                           input int rst_row, input int fs_mid);
    for (int w = 0; w < wait_cyc; w++) begin
      chk("ready_row_valid", 128'(bus.row_valid), 128'(0));
      chk("ready_busy",      128'(busy),          128'(1));
      step();
    end
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    for (int r = 0; r < 16; r++) begin
      chk("row_valid", 128'(bus.row_valid), 128'(1));
      chk("row_idx",   128'(bus.row_idx),   128'(r));
      chk("in_row",    128'(bus.in_row),    128'(exp_row(bx, by, r)));
      chk("done_low",  128'(done),          128'(0));
      chk("busy_str",  128'(busy),          128'(1));
      rows[r] = bus.in_row;
      if (r == rst_row) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle_outputs("abort");
        return;
      end
      if (r == fs_mid) frame_sync = 1'b1;
      step();
      frame_sync = 1'b0;
    end
    chk("done_pulse", 128'(done),          128'(1));
    chk("busy_end",   128'(busy),          128'(0));
    chk("valid_end",  128'(bus.row_valid), 128'(0));
    chk("in_row_end", 128'(bus.in_row),    128'(0));
    step();
    chk("done_one_cycle", 128'(done), 128'(0));
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    frame_sync = 1'b0;
    blk_x      = 8'd0;
    blk_y      = 8'd0;
    step();
    step();
    chk_idle_outputs("reset");
    rst = 1'b0;
    step();

    // Aligned window, single read per row
    do_fetch(0, 0, -1, -1);
    do_stream(0, 0, 0, -1, -1);
    chk("t1_r0_lo",  128'(rows[0][7:0]),     128'(0));
    chk("t1_r0_hi",  128'(rows[0][119:112]), 128'(14));
    chk("t1_r15_lo", 128'(rows[15][7:0]),    128'(45));

    // Offset 1 still fits in one word
    do_fetch(17, 2, -1, -1);
    do_stream(17, 2, 3, -1, -1);
    chk("t2_r0_lo", 128'(rows[0][7:0]),     128'(23));
    chk("t2_r0_hi", 128'(rows[0][119:112]), 128'(37));

    // Straddling window, two reads per row
    do_fetch(20, 0, -1, -1);
    do_stream(20, 0, 0, -1, -1);
    chk("t3_r0_lo",   128'(rows[0][7:0]),     128'(20));
    chk("t3_r0_edge", 128'(rows[0][103:96]),  128'(32));
    chk("t3_r0_hi",   128'(rows[0][119:112]), 128'(34));

    // Stray frame_sync in FETCH and in STREAM
    do_fetch(5, 7, 5, -1);
    do_stream(5, 7, 2, -1, 3);
    chk("t4_r0_lo", 128'(rows[0][7:0]), 128'(26));
    for (int i = 0; i < 3; i++) begin
      chk("t4_quiet_valid", 128'(bus.row_valid), 128'(0));
      step();
    end

    // start during FETCH is ignored
    do_fetch(33, 1, -1, 5);
    do_stream(33, 1, 0, -1, -1);
    chk("t5_r0_lo", 128'(rows[0][7:0]), 128'(36));

    // Reset in the middle of STREAM, then a normal run
    do_fetch(2, 48, -1, -1);
    do_stream(2, 48, 0, 7, -1);
    frame_sync = 1'b1;
    step();
    frame_sync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t6_post_valid", 128'(bus.row_valid), 128'(0));
      chk("t6_post_busy",  128'(busy),          128'(0));
      step();
    end
    do_fetch(46, 10, -1, -1);
    do_stream(46, 10, 1, -1, -1);
    chk("t6_r0_lo", 128'(rows[0][7:0]), 128'(76));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
